// File: rtl/step_meter.sv
// step_meter: receive-side step monitor. Tracks a wrapping signed position from
// a step strobe plus direction. After an arm pulse it counts a requested number
// of steps and measures the cycle interval between consecutive strobes, flagging
// completion (done) or a no-step timeout.
//
// Handshake: step_stb is a plain strobe with no back-pressure. Every cycle it is
// sampled high counts as exactly one step, with dir qualifying it. arm is a
// one-cycle command that captures steps_val and timeout_val on the same edge.
// All outputs are registered and reflect the inputs sampled at the previous edge.
module step_meter (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_stb,
    input  logic        dir,
    input  logic        arm,
    input  logic [31:0] steps_val,
    input  logic [31:0] timeout_val,
    input  logic        pos_clear,
    output logic [31:0] position,
    output logic [31:0] steps,
    output logic [31:0] period,
    output logic [31:0] period_min,
    output logic [31:0] period_max,
    output logic        period_valid,
    output logic        active,
    output logic        done,
    output logic        timeout,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] dt;
    logic [31:0] dt_inc;
    logic [31:0] steps_inc;
    logic [31:0] cap_steps;
    logic [31:0] cap_timeout;
    logic        first_step;
    logic        run_step;
    logic        finish;
    logic        tmo_hit;

    // dt+1 is both the measured period and the timeout test value; it saturates.
    assign dt_inc    = (dt == ALL_ONES) ? dt : dt + 32'd1;
    assign steps_inc = steps + 32'd1;

    // Classify this cycle's event; arm pre-empts both a step and a timeout.
    always_comb begin
        first_step = 1'b0;
        run_step   = 1'b0;
        tmo_hit    = 1'b0;
        if (!arm) begin
            if (step_stb) begin
                first_step = (state == S_ARMED);
                run_step   = (state == S_RUN);
            end else begin
                tmo_hit = (state != S_IDLE) && (cap_timeout != 32'd0)
                          && (dt_inc >= cap_timeout);
            end
        end
    end

    // In ARMED steps is 0, so steps_inc == 1 covers the single-step run as well.
    assign finish = (first_step || run_step) && (steps_inc == cap_steps);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = (steps_val == 32'd0) ? S_IDLE : S_ARMED;
        end else if (finish || tmo_hit) begin
            state_nxt = S_IDLE;
        end else if (first_step) begin
            state_nxt = S_RUN;
        end
    end

    // FSM-derived outputs; both come straight from the state register.
    always_comb begin
        active    = (state != S_IDLE);
        state_dbg = state;
    end

    // Position follows every strobe in any state; clear beats a coincident step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            position <= 32'd0;
        end else if (pos_clear) begin
            position <= 32'd0;
        end else if (step_stb) begin
            position <= dir ? position + 32'd1 : position - 32'd1;
        end
    end

    // Interval counter: restarts on every strobe and on arm, otherwise saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dt <= 32'd0;
        end else if (step_stb || arm) begin
            dt <= 32'd0;
        end else begin
            dt <= dt_inc;
        end
    end

    // Run bookkeeping: arm initialises the run, steps accumulate counts and periods.
    always_ff @(posedge clk) begin
        if (!reset) begin
            steps        <= 32'd0;
            period       <= 32'd0;
            period_min   <= ALL_ONES;
            period_max   <= 32'd0;
            period_valid <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cap_steps    <= 32'd0;
            cap_timeout  <= 32'd0;
        end else if (arm) begin
            steps        <= 32'd0;
            period       <= 32'd0;
            period_min   <= ALL_ONES;
            period_max   <= 32'd0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            cap_steps    <= steps_val;
            cap_timeout  <= timeout_val;
            done         <= (steps_val == 32'd0);
        end else begin
            done <= finish;
            if (first_step) begin
                steps <= steps_inc;
            end
            if (run_step) begin
                steps        <= steps_inc;
                period       <= dt_inc;
                period_valid <= 1'b1;
                if (dt_inc < period_min) begin
                    period_min <= dt_inc;
                end
                if (dt_inc > period_max) begin
                    period_max <= dt_inc;
                end
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_step_meter.sv
// Bench for step_meter: directed stimulus, a behavioural model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_step_meter;

    logic        clk;
    logic        reset;
    logic        step_stb;
    logic        dir;
    logic        arm;
    logic [31:0] steps_val;
    logic [31:0] timeout_val;
    logic        pos_clear;
    logic [31:0] position;
    logic [31:0] steps;
    logic [31:0] period;
    logic [31:0] period_min;
    logic [31:0] period_max;
    logic        period_valid;
    logic        active;
    logic        done;
    logic        timeout;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    step_meter dut (
        .clk          (clk),
        .reset        (reset),
        .step_stb     (step_stb),
        .dir          (dir),
        .arm          (arm),
        .steps_val    (steps_val),
        .timeout_val  (timeout_val),
        .pos_clear    (pos_clear),
        .position     (position),
        .steps        (steps),
        .period       (period),
        .period_min   (period_min),
        .period_max   (period_max),
        .period_valid (period_valid),
        .active       (active),
        .done         (done),
        .timeout      (timeout),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model thinks in terms of "a measurement is in progress", "the first step
    // of the run has not been seen yet" and "edges elapsed since the last step/arm".
    logic [31:0] m_pos      = 32'd0;
    logic [31:0] m_steps    = 32'd0;
    logic [31:0] m_period   = 32'd0;
    logic [31:0] m_min      = 32'hFFFF_FFFF;
    logic [31:0] m_max      = 32'd0;
    logic        m_valid    = 1'b0;
    logic        m_active   = 1'b0;
    logic        m_done     = 1'b0;
    logic        m_timeout  = 1'b0;
    logic        m_awaiting = 1'b0;
    logic [31:0] m_target   = 32'd0;
    logic [31:0] m_tmo      = 32'd0;
    longint      m_since    = 0;

    function automatic longint sat(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 64'sh0000_0000_FFFF_FFFF : v;
    endfunction

    task automatic model_step();
        longint gap;
        if (!reset) begin
            m_pos = 0; m_steps = 0; m_period = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
            m_valid = 0; m_active = 0; m_done = 0; m_timeout = 0; m_awaiting = 0;
            m_target = 0; m_tmo = 0; m_since = 0;
            return;
        end
        m_done = 1'b0;
        if (pos_clear)     m_pos = 32'd0;
        else if (step_stb) m_pos = dir ? m_pos + 32'd1 : m_pos - 32'd1;
        gap = sat(m_since + 1);
        if (arm) begin
            m_steps = 0; m_period = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
            m_valid = 0; m_timeout = 0; m_target = steps_val; m_tmo = timeout_val;
            m_since = 0;
            if (steps_val == 32'd0) begin
                m_done = 1'b1; m_active = 1'b0;
            end else begin
                m_active = 1'b1; m_awaiting = 1'b1;
            end
        end else if (step_stb) begin
            if (m_active) begin
                m_steps = m_steps + 32'd1;
                if (!m_awaiting) begin
                    m_period = gap[31:0];
                    m_valid  = 1'b1;
                    if (gap[31:0] < m_min) m_min = gap[31:0];
                    if (gap[31:0] > m_max) m_max = gap[31:0];
                end
                m_awaiting = 1'b0;
                if (m_steps == m_target) begin
                    m_done = 1'b1; m_active = 1'b0;
                end
            end
            m_since = 0;
        end else begin
            if (m_active && m_tmo != 0 && gap >= longint'(m_tmo)) begin
                m_timeout = 1'b1; m_active = 1'b0;
            end
            m_since = gap;
        end
    endtask

    // Compare on the falling edge (outputs of the last rising edge), then advance
    // the model with the inputs the DUT will sample on the next rising edge.
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            chk("position",     position,              m_pos);
            chk("steps",        steps,                 m_steps);
            chk("period",       period,                m_period);
            chk("period_min",   period_min,            m_min);
            chk("period_max",   period_max,            m_max);
            chk("period_valid", {31'd0, period_valid}, {31'd0, m_valid});
            chk("active",       {31'd0, active},       {31'd0, m_active});
            chk("done",         {31'd0, done},         {31'd0, m_done});
            chk("timeout",      {31'd0, timeout},      {31'd0, m_timeout});
            model_step();
        end
    end

    // ---------------- driver tasks ----------------
    // One call = one sampled rising edge; returns 1 time unit after that edge.
    task automatic cycle(input logic stb, input logic d, input logic a, input logic pc);
        step_stb  = stb;
        dir       = d;
        arm       = a;
        pos_clear = pc;
        @(posedge clk);
        #1;
        step_stb  = 1'b0;
        arm       = 1'b0;
        pos_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_arm(input logic [31:0] sv, input logic [31:0] tv);
        steps_val   = sv;
        timeout_val = tv;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        reset = 1'b0; step_stb = 1'b0; dir = 1'b0; arm = 1'b0;
        steps_val = 32'd0; timeout_val = 32'd0; pos_clear = 1'b0;

        // reset state
        idle(2);
        chk("rst_position",   position,   32'd0);
        chk("rst_period_min", period_min, 32'hFFFF_FFFF);
        chk("rst_active",     {31'd0, active}, 32'd0);
        reset = 1'b1;
        idle(1);

        // idle strobes move position only
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_position", position, 32'd2);
        chk("idle_steps",    steps,    32'd0);
        chk("idle_active",   {31'd0, active}, 32'd0);

        // four steps, 10 cycles apart
        do_arm(32'd4, 32'd0);
        chk("arm4_active", {31'd0, active}, 32'd1);
        idle(2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("arm4_first_steps", steps, 32'd1);
        chk("arm4_first_valid", {31'd0, period_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle(9);
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            chk("arm4_period", period, 32'd10);
        end
        chk("arm4_steps", steps,      32'd4);
        chk("arm4_min",   period_min, 32'd10);
        chk("arm4_max",   period_max, 32'd10);
        chk("arm4_done",  {31'd0, done},   32'd1);
        chk("arm4_idle",  {31'd0, active}, 32'd0);
        idle(1);
        chk("arm4_done_drop", {31'd0, done}, 32'd0);

        // gaps of 7 then 2
        do_arm(32'd3, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(6);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("arm3_period7", period, 32'd7);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("arm3_period", period,     32'd2);
        chk("arm3_min",    period_min, 32'd2);
        chk("arm3_max",    period_max, 32'd7);
        chk("arm3_done",   {31'd0, done}, 32'd1);
        chk("arm3_pos",    position,   32'd9);
        idle(2);

        // timeout 20 cycles after a lone strobe
        do_arm(32'd10, 32'd20);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(19);
        chk("tmo_not_yet", {31'd0, timeout}, 32'd0);
        chk("tmo_active",  {31'd0, active},  32'd1);
        idle(1);
        chk("tmo_set",     {31'd0, timeout}, 32'd1);
        chk("tmo_steps",   steps, 32'd1);
        chk("tmo_idle",    {31'd0, active},  32'd0);
        idle(3);
        chk("tmo_sticky",  {31'd0, timeout}, 32'd1);

        // position wrap and clear precedence
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_position", position, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_down", position, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap_up", position, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_beats_step", position, 32'd0);

        // arm coincident with a strobe while running, then mid-run reset
        do_arm(32'd5, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        steps_val = 32'd5;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rearm_steps", steps,     32'd0);
        chk("rearm_state", {30'd0, state_dbg}, 32'd1);
        chk("rearm_pos",   position,  32'd3);
        chk("rearm_valid", {31'd0, period_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rearm_step1", steps, 32'd1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("midrst_pos",    position,   32'd0);
        chk("midrst_steps",  steps,      32'd0);
        chk("midrst_min",    period_min, 32'hFFFF_FFFF);
        chk("midrst_active", {31'd0, active}, 32'd0);
        chk("midrst_done",   {31'd0, done},   32'd0);
        idle(2);

        // zero-step arm completes immediately
        do_arm(32'd0, 32'd0);
        chk("zero_done",   {31'd0, done},   32'd1);
        chk("zero_active", {31'd0, active}, 32'd0);
        idle(1);

        // back-to-back strobes measure period 1; steps_val = 1 finishes on first step
        do_arm(32'd3, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("b2b_period", period, 32'd1);
        chk("b2b_done",   {31'd0, done}, 32'd1);
        do_arm(32'd1, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("one_done",  {31'd0, done}, 32'd1);
        chk("one_valid", {31'd0, period_valid}, 32'd0);

        // mixed gaps and directions, ending in a timeout
        do_arm(32'd9, 32'd14);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            idle($urandom_range(0, 11));
        end
        idle(16);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
